// File: rtl/msk_unmask_collect.sv
// Output-side share recombiner for the masked AES datapath.
// Registers d-share columns, XOR-reduces them and collects NCOL words.
module msk_unmask_collect #(
  parameter int d    = 2,
  parameter int W    = 32,
  parameter int NCOL = 4
) (
  input  logic              clk,
  input  logic              syn_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W*d-1:0]    in_shares,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W*NCOL-1:0] out_data
);

  localparam int CW = $clog2(NCOL + 1);
  localparam int IW = $clog2(NCOL);

  localparam logic [CW-1:0] FULL_CNT = CW'(NCOL);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCOL - 1);

  logic [CW-1:0]            acc_cnt_q, acc_cnt_d;
  logic [W*d-1:0]           sh_reg_q, sh_reg_d;
  logic [IW-1:0]            wr_idx_q, wr_idx_d;
  logic                     sh_vld_q, sh_vld_d;
  logic [NCOL-1:0][W-1:0]   buf_q, buf_d;
  logic                     ov_q, ov_d;

  logic                     accept;
  logic                     drain;
  logic [W-1:0]             word;

  assign in_ready  = (acc_cnt_q < FULL_CNT);
  assign accept    = in_valid & in_ready;
  assign drain     = ov_q & out_ready;
  assign out_valid = ov_q;

  // Unmasked words only leave the block once it is complete.
  assign out_data  = ov_q ? buf_q : '0;

  // Recombine the registered shares of each bit into the plain word.
  always_comb begin
    word = '0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < d; j++) begin
        word[i] = word[i] ^ sh_reg_q[i*d+j];
      end
    end
  end

  // Next-state: capture shares, write recombined slot, flag full, drain.
  always_comb begin
    acc_cnt_d = acc_cnt_q;
    sh_reg_d  = sh_reg_q;
    wr_idx_d  = wr_idx_q;
    sh_vld_d  = 1'b0;
    buf_d     = buf_q;
    ov_d      = ov_q;

    if (accept) begin
      acc_cnt_d = acc_cnt_q + CW'(1);
      sh_reg_d  = in_shares;
      wr_idx_d  = acc_cnt_q[IW-1:0];
      sh_vld_d  = 1'b1;
    end

    if (sh_vld_q) begin
      buf_d[wr_idx_q] = word;
      if (wr_idx_q == LAST_IDX) begin
        ov_d = 1'b1;
      end
    end

    if (drain) begin
      acc_cnt_d = '0;
      ov_d      = 1'b0;
      buf_d     = '0;
    end
  end

  // State registers, synchronously cleared.
  always_ff @(posedge clk) begin
    if (syn_rst) begin
      acc_cnt_q <= '0;
      sh_reg_q  <= '0;
      wr_idx_q  <= '0;
      sh_vld_q  <= 1'b0;
      buf_q     <= '0;
      ov_q      <= 1'b0;
    end else begin
      acc_cnt_q <= acc_cnt_d;
      sh_reg_q  <= sh_reg_d;
      wr_idx_q  <= wr_idx_d;
      sh_vld_q  <= sh_vld_d;
      buf_q     <= buf_d;
      ov_q      <= ov_d;
    end
  end

endmodule

// File: tb/tb_msk_unmask_collect.sv
// Bench for msk_unmask_collect: directed table, corner sequences,
// and a random run with d=2 plus lockstep d=1 and d=3 instances.
module tb_msk_unmask_collect;

  logic         clk = 1'b0;
  logic         syn_rst;
  logic         in_valid;
  logic         out_ready;
  logic [63:0]  in_shares;
  logic [31:0]  sh1;
  logic [95:0]  sh3;

  logic         in_ready, out_valid;
  logic [127:0] out_data;
  logic         u1_ir, u1_ov, u3_ir, u3_ov;
  logic [127:0] u1_dat, u3_dat;

  int ncmp = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  msk_unmask_collect #(.d(2), .W(32), .NCOL(4)) dut (
    .clk(clk), .syn_rst(syn_rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_shares(in_shares),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  msk_unmask_collect #(.d(1), .W(32), .NCOL(4)) u1 (
    .clk(clk), .syn_rst(syn_rst),
    .in_valid(in_valid), .in_ready(u1_ir),
    .in_shares(sh1),
    .out_valid(u1_ov), .out_ready(out_ready),
    .out_data(u1_dat)
  );

  msk_unmask_collect #(.d(3), .W(32), .NCOL(4)) u3 (
    .clk(clk), .syn_rst(syn_rst),
    .in_valid(in_valid), .in_ready(u3_ir),
    .in_shares(sh3),
    .out_valid(u3_ov), .out_ready(out_ready),
    .out_data(u3_dat)
  );

  typedef struct {
    logic         vld;
    logic [31:0]  s0;
    logic [31:0]  s1;
    logic         ordy;
    logic         e_ir;
    logic         e_ov;
    logic [127:0] e_dat;
  } vec_t;

  function automatic vec_t mk(
    input logic vld, input logic [31:0] s0,
    input logic [31:0] s1, input logic ordy,
    input logic e_ir, input logic e_ov,
    input logic [127:0] e_dat);
    vec_t v;
    v.vld = vld; v.s0 = s0; v.s1 = s1;
    v.ordy = ordy; v.e_ir = e_ir;
    v.e_ov = e_ov; v.e_dat = e_dat;
    return v;
  endfunction

  function automatic logic [63:0] pack2(
    input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    for (int i = 0; i < 32; i++) begin
      r[2*i]   = a[i];
      r[2*i+1] = b[i];
    end
    return r;
  endfunction

  function automatic logic [95:0] pack3(
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] c);
    logic [95:0] r;
    for (int i = 0; i < 32; i++) begin
      r[3*i]   = a[i];
      r[3*i+1] = b[i];
      r[3*i+2] = c[i];
    end
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic put2(input logic [31:0] w);
    logic [31:0] m;
    m = $urandom;
    in_shares = pack2(m, m ^ w);
  endtask

  localparam int NV   = 17;
  localparam int NBLK = 300;
  localparam logic [127:0] BLK =
    {32'hFFFF_FFFC, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFF};

  vec_t         vt [NV];
  logic [31:0]  gw [4];
  logic [6:0]   gpat;
  logic [31:0]  cur [4];
  logic [127:0] expq [$];
  logic [127:0] eb;

  initial begin
    int  acc, ncur, got, nsub, cyc;
    logic pend;
    logic [31:0] word, m, m2;

    for (int k = 0; k < 4; k++) begin
      vt[k] = mk(1'b1, 32'hA5A5_0000 + 32'(k), 32'h5A5A_FFFF,
                 1'b0, 1'b1, 1'b0, 128'h0);
    end
    vt[4] = mk(1'b1, 32'hDEAD_0000, 32'h0, 1'b0, 1'b0, 1'b0, 128'h0);
    for (int k = 5; k < 15; k++) begin
      vt[k] = mk(1'b1, 32'hDEAD_0000 + 32'(k), 32'h0, 1'b0,
                 1'b0, 1'b1, BLK);
    end
    vt[15] = mk(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, BLK);
    vt[16] = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 128'h0);

    syn_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_shares = '0; sh1 = '0; sh3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", out_data, 128'h0);
    syn_rst = 1'b0;

    // Single block, hold with in_valid high, drain
    for (int r = 0; r < NV; r++) begin
      @(negedge clk);
      chk($sformatf("tbl%0d_ir", r), 128'(in_ready), 128'(vt[r].e_ir));
      chk($sformatf("tbl%0d_ov", r), 128'(out_valid), 128'(vt[r].e_ov));
      chk($sformatf("tbl%0d_dat", r), out_data, vt[r].e_dat);
      in_valid  = vt[r].vld;
      in_shares = pack2(vt[r].s0, vt[r].s1);
      out_ready = vt[r].ordy;
    end

    // Gapped input
    gw[0] = 32'h0123_4567; gw[1] = 32'h89AB_CDEF;
    gw[2] = 32'hCAFE_F00D; gw[3] = 32'h1357_9BDF;
    gpat = 7'b1101001;
    acc = 0;
    for (int p = 0; p < 7; p++) begin
      @(negedge clk);
      chk($sformatf("gap%0d_ov", p), 128'(out_valid), 128'(0));
      chk($sformatf("gap%0d_ir", p), 128'(in_ready), 128'(1));
      in_valid = gpat[p];
      if (gpat[p]) begin
        put2(gw[acc]);
        acc++;
      end else begin
        in_shares = {$urandom, $urandom};
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("gap_ov_early", 128'(out_valid), 128'(0));
    @(negedge clk);
    chk("gap_ov", 128'(out_valid), 128'(1));
    chk("gap_dat", out_data, {gw[3], gw[2], gw[1], gw[0]});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("gap_drain_ov", 128'(out_valid), 128'(0));

    // Reset after two accepts, pending share included
    in_valid = 1'b1; put2(32'hBAD0_0001);
    @(negedge clk);
    put2(32'hBAD0_0002);
    @(negedge clk);
    in_valid = 1'b0; syn_rst = 1'b1;
    @(negedge clk);
    syn_rst = 1'b0;
    chk("mrst_ir", 128'(in_ready), 128'(1));
    chk("mrst_ov", 128'(out_valid), 128'(0));
    chk("mrst_dat", out_data, 128'h0);
    gw[0] = 32'h1111_0000; gw[1] = 32'h2222_0001;
    gw[2] = 32'h3333_0002; gw[3] = 32'h4444_0003;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; put2(gw[k]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("mrst_ov_early", 128'(out_valid), 128'(0));
    @(negedge clk);
    chk("mrst_ov", 128'(out_valid), 128'(1));
    chk("mrst_blk", out_data, {gw[3], gw[2], gw[1], gw[0]});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Random shares and handshakes, d=2 with d=1/d=3 in lockstep
    ncur = 0; got = 0; nsub = 0; pend = 1'b0; word = '0;
    cyc = 0;
    while (got < NBLK && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          eb = '0;
          nbad++; ncmp++;
          $display("FAIL rnd_extra_block: got %h expected none",
                   out_data);
        end else begin
          eb = expq.pop_front();
          chk("rnd_d2", out_data, eb);
        end
        chk("rnd_d1", u1_dat, eb);
        chk("rnd_d3", u3_dat, eb);
        chk("rnd_ov13", 128'({u1_ov, u3_ov}), 128'(3));
        got++;
      end
      if (!pend && nsub < NBLK*4 && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        word = $urandom; m = $urandom; m2 = $urandom;
        in_shares = pack2(m, m ^ word);
        sh1 = word;
        sh3 = pack3(m, m2, m ^ m2 ^ word);
        nsub++;
      end
      in_valid = pend;
      if (pend && in_ready) begin
        cur[ncur] = word;
        ncur++;
        pend = 1'b0;
        if (ncur == 4) begin
          expq.push_back({cur[3], cur[2], cur[1], cur[0]});
          ncur = 0;
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rnd_blocks", 128'(got), 128'(NBLK));
    chk("rnd_leftover", 128'(expq.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
